// File: rtl/program_load_sequencer_if.sv
// ---------------------------------------------------------------------------
// program_load_sequencer_if
//
// Bundles the signals between the UART loader, the program load sequencer and
// the instruction memory / CPU core.
//
//   Loader side   : word_valid, word_data, in_execution
//   Memory side   : imem_we, imem_addr, imem_wdata
//   Core control  : cpu_reset, cpu_run
//   Host status   : word_count, checksum, overflow
//
// Modports:
//   slave  - the sequencer itself (consumes loader signals, drives the rest)
//   master - the environment around it (loader, memory, core, host)
// ---------------------------------------------------------------------------
interface program_load_sequencer_if #(
  parameter int ADDR_W = 10
);

  logic              word_valid;
  logic [31:0]       word_data;
  logic              in_execution;

  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  logic              cpu_reset;
  logic              cpu_run;

  logic [ADDR_W:0]   word_count;
  logic [31:0]       checksum;
  logic              overflow;

  modport slave (
    input  word_valid,
    input  word_data,
    input  in_execution,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output cpu_reset,
    output cpu_run,
    output word_count,
    output checksum,
    output overflow
  );

  modport master (
    output word_valid,
    output word_data,
    output in_execution,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  cpu_reset,
    input  cpu_run,
    input  word_count,
    input  checksum,
    input  overflow
  );

endinterface : program_load_sequencer_if

// File: rtl/program_load_sequencer.sv
// ---------------------------------------------------------------------------
// program_load_sequencer
//
// Sits between the UART instruction loader and the CPU core. While the loader
// is in load mode, every assembled word is written to consecutive
// instruction-memory addresses and the core is held in reset. When the loader
// switches to execute mode, reset is held for BOOT_CYCLES more cycles, then the
// core is released. A word count and an XOR checksum of the written words are
// kept so the host can verify the download.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-low reset
//   bus    - program_load_sequencer_if.slave
//              in : word_valid, word_data, in_execution
//              out: imem_we, imem_addr, imem_wdata, cpu_reset, cpu_run,
//                   word_count, checksum, overflow
//
// Parameters:
//   ADDR_W      - instruction memory address width (DEPTH = 2**ADDR_W words)
//   BOOT_CYCLES - cycles cpu_reset stays high after execute mode is entered
//                 (must be >= 1)
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module program_load_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int BOOT_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  program_load_sequencer_if.slave         bus
);

  // -------------------------------------------------------------------------
  // Local constants
  // -------------------------------------------------------------------------
  localparam int unsigned     DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  // Boot counter only needs to reach BOOT_CYCLES-1; keep at least one bit so
  // BOOT_CYCLES == 1 still elaborates.
  localparam int              CNT_W      = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int unsigned     BOOT_LAST_I = BOOT_CYCLES - 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = BOOT_LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  // Running checksum: plain XOR fold of each accepted word.
  function automatic logic [31:0] checksum_fold(input logic [31:0] acc,
                                                input logic [31:0] word);
    return acc ^ word;
  endfunction

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  state_t            state_r;
  logic [CNT_W-1:0]  boot_cnt_r;
  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;
  logic              cpu_reset_r;
  logic              cpu_run_r;
  logic [ADDR_W:0]   word_count_r;
  logic [31:0]       checksum_r;
  logic              overflow_r;

  // Memory is full once the count reaches DEPTH; the count never goes beyond.
  logic              mem_full_s;
  assign mem_full_s = (word_count_r == FULL_COUNT);

  // Sequencer FSM with all outputs registered in the same block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_LOAD;
      boot_cnt_r   <= {CNT_W{1'b0}};
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {ADDR_W{1'b0}};
      imem_wdata_r <= 32'h0000_0000;
      cpu_reset_r  <= 1'b1;
      cpu_run_r    <= 1'b0;
      word_count_r <= {(ADDR_W+1){1'b0}};
      checksum_r   <= 32'h0000_0000;
      overflow_r   <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse; it is re-armed only when a
      // word is accepted below.
      imem_we_r <= 1'b0;

      case (state_r)
        ST_LOAD: begin
          cpu_reset_r <= 1'b1;
          cpu_run_r   <= 1'b0;
          if (bus.in_execution) begin
            // Mode switch wins over a coincident word strobe: that word is
            // discarded rather than half-committed.
            state_r    <= ST_BOOT;
            boot_cnt_r <= {CNT_W{1'b0}};
          end else if (bus.word_valid) begin
            if (!mem_full_s) begin
              imem_we_r    <= 1'b1;
              imem_addr_r  <= word_count_r[ADDR_W-1:0];
              imem_wdata_r <= bus.word_data;
              word_count_r <= word_count_r + COUNT_ONE;
              checksum_r   <= checksum_fold(checksum_r, bus.word_data);
            end else begin
              overflow_r <= 1'b1;
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end

        ST_BOOT: begin
          if (!bus.in_execution) begin
            // Boot aborted: back to a clean load session.
            state_r      <= ST_LOAD;
            cpu_reset_r  <= 1'b1;
            cpu_run_r    <= 1'b0;
            word_count_r <= {(ADDR_W+1){1'b0}};
            checksum_r   <= 32'h0000_0000;
            overflow_r   <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
          end else if (boot_cnt_r == BOOT_LAST) begin
            // Release reset and start the core on the same edge.
            state_r     <= ST_RUN;
            cpu_reset_r <= 1'b0;
            cpu_run_r   <= 1'b1;
          end else begin
            boot_cnt_r  <= boot_cnt_r + CNT_ONE;
            cpu_reset_r <= 1'b1;
            cpu_run_r   <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!bus.in_execution) begin
            state_r      <= ST_LOAD;
            cpu_reset_r  <= 1'b1;
            cpu_run_r    <= 1'b0;
            word_count_r <= {(ADDR_W+1){1'b0}};
            checksum_r   <= 32'h0000_0000;
            overflow_r   <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
          end else begin
            cpu_reset_r <= 1'b0;
            cpu_run_r   <= 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: recover into a safe, core-held-in-reset state.
          state_r      <= ST_LOAD;
          boot_cnt_r   <= {CNT_W{1'b0}};
          cpu_reset_r  <= 1'b1;
          cpu_run_r    <= 1'b0;
          word_count_r <= {(ADDR_W+1){1'b0}};
          checksum_r   <= 32'h0000_0000;
          overflow_r   <= 1'b0;
          imem_addr_r  <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign bus.cpu_reset  = cpu_reset_r;
  assign bus.cpu_run    = cpu_run_r;
  assign bus.word_count = word_count_r;
  assign bus.checksum   = checksum_r;
  assign bus.overflow   = overflow_r;

endmodule : program_load_sequencer

// File: tb/tb_program_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_program_load_sequencer
//
// Directed bench for program_load_sequencer with ADDR_W=2 (4-word memory) and
// BOOT_CYCLES=4. Every word the stimulus expects to be written is pushed into
// a queue; a monitor on the falling clock edge pops and compares whenever the
// DUT raises imem_we. Status outputs are checked directly by the stimulus.
// ---------------------------------------------------------------------------
module tb_program_load_sequencer;

  localparam int ADDR_W      = 2;
  localparam int BOOT_CYCLES = 4;
  localparam int DEPTH       = 1 << ADDR_W;

  logic clk;
  logic reset;

  program_load_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  program_load_sequencer #(
    .ADDR_W      (ADDR_W),
    .BOOT_CYCLES (BOOT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];

  // Bench-side model of the load session
  int          m_count = 0;
  logic [31:0] m_cksum = 32'h0;
  logic        m_loading = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one cycle; the model decides whether it is written.
  task automatic send_word(input logic [31:0] d);
    wr_t w;
    bus.word_valid = 1'b1;
    bus.word_data  = d;
    if (m_loading && !bus.in_execution && reset) begin
      if (m_count < DEPTH) begin
        w.addr = m_count[ADDR_W-1:0];
        w.data = d;
        exp_q.push_back(w);
        m_count++;
        m_cksum ^= d;
      end
    end
    tick();
    bus.word_valid = 1'b0;
    bus.word_data  = 32'h0;
  endtask

  task automatic model_clear();
    m_count = 0;
    m_cksum = 32'h0;
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t w;
    if (bus.imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual_addr=%0h actual_data=%0h required=no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        w = exp_q.pop_front();
        if (bus.imem_addr !== w.addr || bus.imem_wdata !== w.data) begin
          errors++;
          $display("FAIL write actual=%0h/%0h required=%0h/%0h",
                   bus.imem_addr, bus.imem_wdata, w.addr, w.data);
        end
      end
    end
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset            = 1'b0;
    bus.word_valid   = 1'b0;
    bus.word_data    = 32'h0;
    bus.in_execution = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_cpu_reset", 64'(bus.cpu_reset), 64'd1);
    check("rst_cpu_run",   64'(bus.cpu_run),   64'd0);
    check("rst_imem_we",   64'(bus.imem_we),   64'd0);
    check("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
    check("rst_wdata",     64'(bus.imem_wdata), 64'd0);
    check("rst_count",     64'(bus.word_count), 64'd0);
    check("rst_cksum",     64'(bus.checksum),  64'd0);
    check("rst_overflow",  64'(bus.overflow),  64'd0);
    reset = 1'b1;
    tick();

    // Load three words
    send_word(32'h2001_0005);
    send_word(32'h2002_0003);
    send_word(32'h0022_1820);
    tick();
    check("load3_count", 64'(bus.word_count), 64'd3);
    check("load3_cksum", 64'(bus.checksum), 64'h0021_1826);
    check("load3_cpu_reset", 64'(bus.cpu_reset), 64'd1);
    check("load3_addr_hold", 64'(bus.imem_addr), 64'd2);
    check("load3_data_hold", 64'(bus.imem_wdata), 64'h0022_1820);

    // Boot sequencing: a strobe in the mode-switch cycle is ignored
    bus.in_execution = 1'b1;
    m_loading = 1'b0;
    send_word(32'hDEAD_0001);
    for (int i = 0; i < BOOT_CYCLES; i++) begin
      check($sformatf("boot_reset_%0d", i), 64'(bus.cpu_reset), 64'd1);
      check($sformatf("boot_run_%0d", i), 64'(bus.cpu_run), 64'd0);
      if (i == 1) send_word(32'hDEAD_0002);
      else tick();
    end
    check("run_cpu_reset", 64'(bus.cpu_reset), 64'd0);
    check("run_cpu_run",   64'(bus.cpu_run),   64'd1);
    send_word(32'hDEAD_0003);
    check("run_count_kept", 64'(bus.word_count), 64'd3);
    check("run_cksum_kept", 64'(bus.checksum), 64'h0021_1826);

    // Return to load
    bus.in_execution = 1'b0;
    tick();
    m_loading = 1'b1;
    model_clear();
    check("ret_cpu_reset", 64'(bus.cpu_reset), 64'd1);
    check("ret_cpu_run",   64'(bus.cpu_run),   64'd0);
    check("ret_count",     64'(bus.word_count), 64'd0);
    check("ret_cksum",     64'(bus.checksum),  64'd0);
    check("ret_addr",      64'(bus.imem_addr), 64'd0);
    send_word(32'h1234_5678);
    tick();
    check("ret_word_count", 64'(bus.word_count), 64'd1);

    // Abort boot after two cycles
    bus.in_execution = 1'b1;
    m_loading = 1'b0;
    tick();
    tick();
    check("abort_run_mid", 64'(bus.cpu_run), 64'd0);
    bus.in_execution = 1'b0;
    tick();
    m_loading = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abort_run_%0d", i), 64'(bus.cpu_run), 64'd0);
      check($sformatf("abort_reset_%0d", i), 64'(bus.cpu_reset), 64'd1);
      tick();
    end
    check("abort_count", 64'(bus.word_count), 64'd0);
    check("abort_cksum", 64'(bus.checksum), 64'd0);

    // Overflow: five words into a four-word memory
    send_word(32'h0000_0011);
    send_word(32'h0000_0022);
    send_word(32'h0000_0044);
    send_word(32'h0000_0088);
    check("pre_ovf_flag", 64'(bus.overflow), 64'd0);
    send_word(32'h0000_0100);
    tick();
    check("ovf_flag",  64'(bus.overflow),  64'd1);
    check("ovf_count", 64'(bus.word_count), 64'd4);
    check("ovf_cksum", 64'(bus.checksum),  64'h0000_00FF);
    check("ovf_addr_hold", 64'(bus.imem_addr), 64'd3);

    // Into RUN with overflow still flagged, then reset mid-run with a strobe
    bus.in_execution = 1'b1;
    m_loading = 1'b0;
    for (int i = 0; i < BOOT_CYCLES + 1; i++) tick();
    check("run2_cpu_run",  64'(bus.cpu_run),  64'd1);
    check("run2_overflow", 64'(bus.overflow), 64'd1);
    reset = 1'b0;
    bus.in_execution = 1'b0;
    send_word(32'hBAD0_BAD0);
    reset = 1'b1;
    m_loading = 1'b1;
    model_clear();
    check("mrst_cpu_reset", 64'(bus.cpu_reset), 64'd1);
    check("mrst_cpu_run",   64'(bus.cpu_run),   64'd0);
    check("mrst_count",     64'(bus.word_count), 64'd0);
    check("mrst_overflow",  64'(bus.overflow),  64'd0);
    check("mrst_cksum",     64'(bus.checksum),  64'd0);
    tick();

    // Overflow again, then clear it by re-entering LOAD through BOOT
    for (int i = 0; i < DEPTH + 1; i++) send_word(32'(i + 1));
    tick();
    check("ovf2_flag", 64'(bus.overflow), 64'd1);
    bus.in_execution = 1'b1;
    m_loading = 1'b0;
    tick();
    check("ovf2_held_in_boot", 64'(bus.overflow), 64'd1);
    bus.in_execution = 1'b0;
    tick();
    m_loading = 1'b1;
    model_clear();
    check("ovf2_cleared", 64'(bus.overflow), 64'd0);
    send_word(32'hCAFE_F00D);
    tick();
    tick();

    check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_program_load_sequencer
